// File: rtl/ringosc_pkg.sv
// Shared definitions for the ring-oscillator calibration controller.
//   cal_state_e    : calibration FSM states (also exported on state_dbg)
//   TRIM_LEVELS    : number of trim levels for the default 26-bit trim bus
//   THERM_W        : widest thermometer code the helper can build
//   level_to_therm : trim level -> thermometer code (low 'level' bits set)
package ringosc_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    SETTLE        = 3'd1,
    MEASURE       = 3'd2,
    COMPARE       = 3'd3,
    FINAL_SETTLE  = 3'd4,
    FINAL_MEASURE = 3'd5,
    DONE          = 3'd6
  } cal_state_e;

  localparam int TRIM_LEVELS = 27;
  localparam int THERM_W     = 31;

  function automatic logic [THERM_W-1:0] level_to_therm(input logic [4:0] level);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W; i++) begin
      t[i] = (i < int'(level));
    end
    return t;
  endfunction

endpackage

// File: rtl/ringosc_edge_counter.sv
// Counts rising edges of an asynchronous oscillator clock.
//   clk, rst    : controller clock, synchronous active-high reset
//   osc_clk_in  : asynchronous oscillator output
//   clear       : zero the count (takes effect at the next clock edge)
//   enable      : count detected rising edges while high
//   count       : running total including an edge detected this cycle,
//                 so a caller can capture the full window on its last cycle
// The count saturates at all-ones.
module ringosc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_clk_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic             sync1, sync2, sync3;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;

  // sync1/sync2 form the two-flop synchronizer; sync3 is the edge-detect delay.
  assign rise = sync2 & ~sync3;

  always_comb begin
    count = cnt_q;
    if (clear) begin
      count = '0;
    end else if (enable && rise && (cnt_q != '1)) begin
      count = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1 <= osc_clk_in;
      sync2 <= sync1;
      sync3 <= sync2;
      cnt_q <= count;
    end
  end

endmodule

// File: rtl/ringosc_cal_ctrl.sv
// Ring-oscillator trim calibration by bisection over TRIM_BITS+1 levels.
// Each step: settle SETTLE_CYCLES, count oscillator edges for a window,
// then move lo/hi. When lo==hi the chosen level is settled and measured once
// more; trim_ok reports whether that last count lies within TOL of target.
//   Inputs : wb_clk_i, wb_rst_i (sync, active-high), cal_start, hold_en,
//            clkmux_sel[2:0], target_count, window_cycles, osc_clk_in
//   Outputs: osc_start, trim_a (thermometer), clkmux, busy, done, trim_ok,
//            trim_level[4:0], meas_count, state_dbg[2:0] (FSM state)
// Optional macro RINGOSC_CAL_MANUAL_EN adds manual_en / manual_level, which
// set the trim level directly while the controller is idle or done.
//
// Request protocol: cal_start is a single-cycle request. It is accepted only
// in IDLE or DONE (and, with manual mode built in, only while manual_en is
// low); a pulse in any other state is dropped, there is no queueing.
module ringosc_cal_ctrl
  import ringosc_pkg::*;
#(
  parameter int TRIM_BITS     = 26,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int TOL           = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cal_start,
  input  logic                 hold_en,
  input  logic [2:0]           clkmux_sel,
  input  logic [CNT_W-1:0]     target_count,
  input  logic [CNT_W-1:0]     window_cycles,
  input  logic                 osc_clk_in,
`ifdef RINGOSC_CAL_MANUAL_EN
  input  logic                 manual_en,
  input  logic [4:0]           manual_level,
`endif
  output logic                 osc_start,
  output logic [TRIM_BITS-1:0] trim_a,
  output logic [2:0]           clkmux,
  output logic                 busy,
  output logic                 done,
  output logic                 trim_ok,
  output logic [4:0]           trim_level,
  output logic [CNT_W-1:0]     meas_count,
  output logic [2:0]           state_dbg
);

  localparam logic [4:0]       TOP_LEVEL   = 5'(TRIM_BITS);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  cal_state_e       state, state_nxt;
  logic [4:0]       lo, hi, lo_nxt, hi_nxt, mid;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;  // shared settle / window down-counter
  logic [CNT_W-1:0] meas_nxt, win_load, edge_cnt, diff;
  logic             done_nxt, ok_nxt, busy_nxt, within_tol;
  logic [2:0]       clkmux_nxt;
  logic             cnt_clear, cnt_en;
  logic             manual_hold;
  logic [4:0]       manual_clamped;

`ifdef RINGOSC_CAL_MANUAL_EN
  assign manual_hold    = manual_en;
  assign manual_clamped = (manual_level > TOP_LEVEL) ? TOP_LEVEL : manual_level;
`else
  assign manual_hold    = 1'b0;
  assign manual_clamped = 5'd0;
`endif

  ringosc_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .osc_clk_in (osc_clk_in),
    .clear      (cnt_clear),
    .enable     (cnt_en),
    .count      (edge_cnt)
  );

  assign mid        = 5'((6'(lo) + 6'(hi)) >> 1);
  // A zero window still measures for one cycle so the FSM always advances.
  assign win_load   = (window_cycles == '0) ? '0 : window_cycles - CNT_W'(1);
  assign diff       = (edge_cnt >= target_count) ? edge_cnt - target_count
                                                 : target_count - edge_cnt;
  assign within_tol = (diff <= CNT_W'(TOL));

  always_comb begin
    state_nxt   = state;
    lo_nxt      = lo;
    hi_nxt      = hi;
    cyc_cnt_nxt = cyc_cnt;
    meas_nxt    = meas_count;
    done_nxt    = done;
    ok_nxt      = trim_ok;
    clkmux_nxt  = clkmux;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (manual_hold) begin
          lo_nxt = manual_clamped;
        end else if (cal_start) begin
          lo_nxt      = 5'd0;
          hi_nxt      = TOP_LEVEL;
          done_nxt    = 1'b0;
          ok_nxt      = 1'b0;
          clkmux_nxt  = clkmux_sel;
          cyc_cnt_nxt = SETTLE_LOAD;
          state_nxt   = SETTLE;
        end
      end
      SETTLE, FINAL_SETTLE: begin
        if (cyc_cnt == '0) begin
          // window_cycles is sampled here, on entry to the measurement
          cyc_cnt_nxt = win_load;
          cnt_clear   = 1'b1;
          state_nxt   = (state == SETTLE) ? MEASURE : FINAL_MEASURE;
        end else begin
          cyc_cnt_nxt = cyc_cnt - CNT_W'(1);
        end
      end
      MEASURE, FINAL_MEASURE: begin
        cnt_en = 1'b1;
        if (cyc_cnt == '0) begin
          meas_nxt = edge_cnt;
          if (state == MEASURE) begin
            state_nxt = COMPARE;
          end else begin
            ok_nxt    = within_tol;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          cyc_cnt_nxt = cyc_cnt - CNT_W'(1);
        end
      end
      COMPARE: begin
        // Higher count means the oscillator is too fast: trim further up.
        if (meas_count > target_count) lo_nxt = mid + 5'd1;
        else                           hi_nxt = mid;
        state_nxt   = (lo_nxt == hi_nxt) ? FINAL_SETTLE : SETTLE;
        cyc_cnt_nxt = SETTLE_LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      lo         <= 5'd0;
      hi         <= TOP_LEVEL;
      cyc_cnt    <= '0;
      meas_count <= '0;
      done       <= 1'b0;
      trim_ok    <= 1'b0;
      clkmux     <= 3'd0;
      osc_start  <= 1'b0;
    end else begin
      state      <= state_nxt;
      lo         <= lo_nxt;
      hi         <= hi_nxt;
      cyc_cnt    <= cyc_cnt_nxt;
      meas_count <= meas_nxt;
      done       <= done_nxt;
      trim_ok    <= ok_nxt;
      clkmux     <= clkmux_nxt;
      // Registered from the next-state busy so it lines up with busy.
      osc_start  <= busy_nxt | hold_en;
    end
  end

  assign busy       = (state != IDLE) && (state != DONE);
  assign trim_level = (state == SETTLE || state == MEASURE || state == COMPARE) ? mid : lo;
  assign trim_a     = TRIM_BITS'(level_to_therm(trim_level));
  assign state_dbg  = state;

endmodule

// File: tb/tb_ringosc_cal_ctrl.sv
// Bench for ringosc_cal_ctrl: a table of calibration vectors, randomized
// oscillator characteristics against a linear-search reference model, and
// hand-written sequences for busy-time requests, mid-measure reset, and
// (when RINGOSC_CAL_MANUAL_EN is defined) manual trim.
//
// Oscillator model: during each measurement the number of rising edges is
// rate(level) = osc_base - osc_slope*level, delivered as 1-high/1-low pulses
// starting 4 cycles into the window. 200 rises need at least 400 sampled
// cycles behind the two-flop synchronizer, so the 200-6*level vectors use a
// 512-cycle window.
module tb_ringosc_cal_ctrl;
  import ringosc_pkg::*;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cal_start = 1'b0;
  logic        hold_en = 1'b0;
  logic [2:0]  clkmux_sel = 3'd0;
  logic [15:0] target_count = 16'd0;
  logic [15:0] window_cycles = 16'd0;
  logic        osc_clk_in = 1'b0;
`ifdef RINGOSC_CAL_MANUAL_EN
  logic        manual_en = 1'b0;
  logic [4:0]  manual_level = 5'd0;
`endif
  logic        osc_start;
  logic [25:0] trim_a;
  logic [2:0]  clkmux;
  logic        busy, done, trim_ok;
  logic [4:0]  trim_level;
  logic [15:0] meas_count;
  logic [2:0]  state_dbg;

  ringosc_cal_ctrl dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .cal_start     (cal_start),
    .hold_en       (hold_en),
    .clkmux_sel    (clkmux_sel),
    .target_count  (target_count),
    .window_cycles (window_cycles),
    .osc_clk_in    (osc_clk_in),
`ifdef RINGOSC_CAL_MANUAL_EN
    .manual_en     (manual_en),
    .manual_level  (manual_level),
`endif
    .osc_start     (osc_start),
    .trim_a        (trim_a),
    .clkmux        (clkmux),
    .busy          (busy),
    .done          (done),
    .trim_ok       (trim_ok),
    .trim_level    (trim_level),
    .meas_count    (meas_count),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- oscillator model ----------------
  int osc_base  = 200;
  int osc_slope = 6;
  int meas_idx  = 0;
  int meas_entries = 0;   // monotonic; tests take differences
  bit in_meas   = 1'b0;
  int done_rises = 0;     // monotonic
  bit done_prev = 1'b0;

  function automatic int osc_rate(input int level);
    int r;
    r = osc_base - osc_slope * level;
    return (r < 0) ? 0 : r;
  endfunction

  // Bisection on a decreasing rate lands on the first level whose count
  // does not exceed the target, or the top level if none does.
  function automatic int model_level(input int target);
    for (int l = 0; l <= 26; l++) begin
      if (osc_rate(l) <= target) return l;
    end
    return 26;
  endfunction

  always @(negedge clk) begin
    cal_state_e st;
    int n;
    st = cal_state_e'(state_dbg);
    if (st == MEASURE || st == FINAL_MEASURE) begin
      if (!in_meas) begin
        meas_idx = 0;
        meas_entries++;
      end else begin
        meas_idx++;
      end
      in_meas = 1'b1;
      n = osc_rate($countones(trim_a));
      osc_clk_in = (meas_idx >= 4) && (meas_idx < 4 + 2 * n) && (((meas_idx - 4) % 2) == 0);
    end else begin
      in_meas    = 1'b0;
      osc_clk_in = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (done && !done_prev) done_rises++;
    done_prev = done;
  end

  // ---------------- driver tasks ----------------
  task automatic start_cal(input logic [15:0] tgt, input logic [15:0] win,
                           input logic [2:0] sel, input logic hold);
    @(negedge clk);
    target_count  = tgt;
    window_cycles = win;
    clkmux_sel    = sel;
    hold_en       = hold;
    cal_start     = 1'b1;
    @(negedge clk);
    cal_start  = 1'b0;
    clkmux_sel = ~sel;   // capture must hold the value seen at the request
  endtask

  task automatic wait_done(output bit ok);
    int c;
    c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    ok = done;
  endtask

  function automatic logic [25:0] therm(input int level);
    logic [25:0] t;
    t = '0;
    for (int i = 0; i < level; i++) t[i] = 1'b1;
    return t;
  endfunction

  // Runs a full calibration and checks every result field.
  task automatic run_and_check(input string tag, input logic [15:0] tgt,
                               input logic [15:0] win, input logic [2:0] sel,
                               input logic hold, input int exp_level,
                               input int exp_meas, input bit exp_ok);
    int m0;
    bit ok;
    m0 = meas_entries;
    start_cal(tgt, win, sel, hold);
    @(negedge clk);
    chk({tag, " busy_run"}, busy, 1);
    chk({tag, " osc_start_run"}, osc_start, 1);
    wait_done(ok);
    chk({tag, " done"}, ok, 1);
    @(negedge clk);
    chk({tag, " trim_level"}, trim_level, exp_level);
    chk({tag, " trim_a"}, trim_a, therm(exp_level));
    chk({tag, " meas_count"}, meas_count, exp_meas);
    chk({tag, " trim_ok"}, trim_ok, exp_ok);
    chk({tag, " busy_done"}, busy, 0);
    chk({tag, " osc_start_done"}, osc_start, hold);
    chk({tag, " clkmux"}, clkmux, sel);
    chk({tag, " meas_le6"}, ((meas_entries - m0) <= 6) && ((meas_entries - m0) >= 1), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] target;
    logic [15:0] window;
    logic [2:0]  sel;
    logic        hold;
    int          exp_level;
    int          exp_meas;
    bit          exp_ok;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int m0, d0, c;

    vecs[0] = '{16'd140,   16'd512, 3'd3, 1'b0, 10, 140, 1'b1};
    vecs[1] = '{16'd0,     16'd512, 3'd5, 1'b1, 26,  44, 1'b0};
    vecs[2] = '{16'd60000, 16'd512, 3'd1, 1'b0,  0, 200, 1'b0};
    vecs[3] = '{16'd132,   16'd512, 3'd6, 1'b1, 12, 128, 1'b1};  // |diff| = TOL
    vecs[4] = '{16'd133,   16'd512, 3'd2, 1'b0, 12, 128, 1'b0};  // |diff| = TOL+1
    vecs[5] = '{16'd100,   16'd512, 3'd7, 1'b0, 17,  98, 1'b1};
    vecs[6] = '{16'd44,    16'd512, 3'd4, 1'b0, 26,  44, 1'b1};
    vecs[7] = '{16'd140,   16'd0,   3'd1, 1'b0,  0,   0, 1'b0};  // zero window

    // ---- reset state ----
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst trim_level", trim_level, 0);
    chk("rst trim_a", trim_a, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst trim_ok", trim_ok, 0);
    chk("rst meas_count", meas_count, 0);
    chk("rst clkmux", clkmux, 0);
    chk("rst osc_start", osc_start, 0);

    // ---- table vectors ----
    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].target, vecs[i].window,
                    vecs[i].sel, vecs[i].hold, vecs[i].exp_level,
                    vecs[i].exp_meas, vecs[i].exp_ok);
    end

    // ---- cal_start repeated while busy is ignored ----
    m0 = meas_entries;
    d0 = done_rises;
    start_cal(16'd140, 16'd512, 3'd2, 1'b0);
    c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
      cal_start = ((c % 97) == 0);
    end
    cal_start = 1'b0;
    chk("busy_req done", done, 1);
    @(negedge clk);
    chk("busy_req trim_level", trim_level, 10);
    chk("busy_req meas_count", meas_count, 140);
    chk("busy_req trim_ok", trim_ok, 1);
    chk("busy_req measurements", meas_entries - m0, 6);
    chk("busy_req done_rises", done_rises - d0, 1);

    // ---- reset during the third measurement ----
    m0 = meas_entries;
    start_cal(16'd140, 16'd512, 3'd5, 1'b1);
    c = 0;
    while (!((meas_entries - m0) == 3 && in_meas && meas_idx >= 20) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("midrst reached", (meas_entries - m0) == 3 && in_meas, 1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst trim_ok", trim_ok, 0);
    chk("midrst trim_level", trim_level, 0);
    chk("midrst trim_a", trim_a, 0);
    chk("midrst clkmux", clkmux, 0);
    chk("midrst meas_count", meas_count, 0);
    chk("midrst osc_start", osc_start, 0);
    wb_rst_i = 1'b0;
    hold_en  = 1'b0;
    run_and_check("after_rst", 16'd140, 16'd512, 3'd3, 1'b0, 10, 140, 1'b1);

    // ---- randomized oscillator characteristics ----
    for (int r = 0; r < 6; r++) begin
      int w, tgt, el;
      w         = $urandom_range(80, 400);
      osc_base  = $urandom_range(30, (w - 8) / 2);
      osc_slope = $urandom_range(0, osc_base / 26);
      tgt       = $urandom_range(0, osc_base + 10);
      el        = model_level(tgt);
      run_and_check($sformatf("rnd%0d", r), 16'(tgt), 16'(w), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), el, osc_rate(el),
                    ((osc_rate(el) > tgt) ? osc_rate(el) - tgt : tgt - osc_rate(el)) <= 4);
    end

`ifdef RINGOSC_CAL_MANUAL_EN
    // ---- manual trim ----
    @(negedge clk);
    manual_en    = 1'b1;
    manual_level = 5'd31;
    @(negedge clk);
    @(negedge clk);
    chk("man trim_level", trim_level, 26);
    chk("man trim_a", trim_a, therm(26));
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("man busy", busy, 0);
    manual_level = 5'd5;
    @(negedge clk);
    @(negedge clk);
    chk("man level5", trim_level, 5);
    manual_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
